// File: rtl/counter_monitor.sv
// Observer for a WIDTH-bit up/down counter: predicts each next value, flags broken steps, reports wraps.
// One clock from an enabled sample to every output update; all outputs are registered.
// No backpressure: samples are accepted every cycle sample_enable is high.
module counter_monitor #(
  parameter int WIDTH  = 4,
  parameter int RELOCK = 2   // consecutive matches needed to leave ERROR, 1..7
) (
  input  logic             clock_signal,
  input  logic             reset_signal,
  input  logic             sample_enable,
  input  logic             up_down,
  input  logic             clear_expect,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] expected_out,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap_pulse,
  output logic [3:0]       error_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [2:0]       RELOCK_TGT = 3'(RELOCK);

  state_t           state;
  logic [2:0]       relock_cnt;
  logic [WIDTH-1:0] last_sample;
  logic             last_up;

  logic             hit;
  logic [WIDTH-1:0] predicted;
  logic             wrap_seen;
  logic [2:0]       relock_next;

  // Next-value prediction and match/wrap qualifiers for the current sample
  always_comb begin
    hit         = (count_in == expected_out);
    predicted   = up_down ? (count_in + CNT_ONE) : (count_in - CNT_ONE);
    // A wrap is a matched step leaving the top going up, or leaving zero going down
    wrap_seen   = (last_up && (last_sample == CNT_MAX)) ||
                  (!last_up && (last_sample == '0));
    relock_next = relock_cnt + 3'd1;
  end

  // Tracking FSM with all outputs registered alongside the state
  always_ff @(posedge clock_signal or negedge reset_signal) begin
    if (!reset_signal) begin
      state        <= IDLE;
      relock_cnt   <= '0;
      last_sample  <= '0;
      last_up      <= 1'b0;
      expected_out <= '0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      wrap_pulse   <= 1'b0;
      error_count  <= '0;
    end else begin
      mismatch   <= 1'b0;
      wrap_pulse <= 1'b0;
      if (sample_enable) begin
        last_sample  <= count_in;
        last_up      <= up_down;
        expected_out <= predicted;
        case (state)
          IDLE: begin
            // First sample only acquires the sequence; nothing to compare against yet
            state  <= LOCKED;
            locked <= 1'b1;
          end
          LOCKED: begin
            if (hit) begin
              wrap_pulse <= wrap_seen;
            end else begin
              mismatch   <= 1'b1;
              relock_cnt <= '0;
              state      <= ERROR;
              locked     <= 1'b0;
              if (error_count != 4'hF) begin
                error_count <= error_count + 4'd1;
              end
            end
          end
          ERROR: begin
            // Errors are counted once per loss of lock, so no pulse or count here
            if (hit) begin
              if (relock_next >= RELOCK_TGT) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                relock_cnt <= '0;
              end else begin
                relock_cnt <= relock_next;
              end
            end else begin
              relock_cnt <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // A producer clear wins over any prediction from a simultaneous sample
      if (clear_expect) begin
        expected_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against an arithmetic model of the counter-checking rules.
module tb_counter_monitor;

  localparam int WIDTH  = 4;
  localparam int RELOCK = 2;
  localparam int MODN   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             dir = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] cnt = '0;
  logic [WIDTH-1:0] expected_out;
  logic             locked;
  logic             mismatch;
  logic             wrap_pulse;
  logic [3:0]       error_count;

  int total = 0;
  int bad   = 0;

  counter_monitor #(.WIDTH(WIDTH), .RELOCK(RELOCK)) dut (
    .clock_signal (clk),
    .reset_signal (rst),
    .sample_enable(en),
    .up_down      (dir),
    .clear_expect (clr),
    .count_in     (cnt),
    .expected_out (expected_out),
    .locked       (locked),
    .mismatch     (mismatch),
    .wrap_pulse   (wrap_pulse),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  // Reference model: acquired/locked flags, pending prediction, run of good samples
  bit m_acq   = 0;
  bit m_lock  = 0;
  int m_exp   = 0;
  int m_last  = 0;
  bit m_up    = 0;
  int m_errs  = 0;
  int m_run   = 0;
  bit m_mis   = 0;
  bit m_wrap  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acq = 0; m_lock = 0; m_exp = 0; m_last = 0; m_up = 0;
      m_errs = 0; m_run = 0; m_mis = 0; m_wrap = 0;
    end else begin
      m_mis  = 0;
      m_wrap = 0;
      if (en) begin
        if (!m_acq) begin
          m_acq  = 1;
          m_lock = 1;
        end else if (m_lock) begin
          if (int'(cnt) == m_exp) begin
            m_wrap = (m_up && m_last == MODN - 1) || (!m_up && m_last == 0);
          end else begin
            m_mis  = 1;
            m_errs = (m_errs < 15) ? m_errs + 1 : 15;
            m_lock = 0;
            m_run  = 0;
          end
        end else begin
          if (int'(cnt) == m_exp) begin
            m_run = m_run + 1;
            if (m_run >= RELOCK) begin
              m_lock = 1;
              m_run  = 0;
            end
          end else begin
            m_run = 0;
          end
        end
        m_last = int'(cnt);
        m_up   = dir;
        m_exp  = (int'(cnt) + (dir ? 1 : MODN - 1)) % MODN;
      end
      if (clr) m_exp = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cyc_expected", int'(expected_out), m_exp);
    check("cyc_locked",   int'(locked),       int'(m_lock));
    check("cyc_mismatch", int'(mismatch),     int'(m_mis));
    check("cyc_wrap",     int'(wrap_pulse),   int'(m_wrap));
    check("cyc_errcnt",   int'(error_count),  m_errs);
  end

  // Drive one cycle of inputs; returns 1 time unit after the edge that took them
  task automatic step(input bit e, input int v, input bit d, input bit c);
    en  = e;
    cnt = WIDTH'(v);
    dir = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 0;
    clr = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  int wraps;
  int mis_seen;
  int x;

  initial begin
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_expected", int'(expected_out), 0);
    check("rst_locked",   int'(locked), 0);
    check("rst_errcnt",   int'(error_count), 0);
    rst = 1;

    // Up-count through a full wrap
    wraps = 0; mis_seen = 0;
    for (int i = 0; i <= 16; i++) begin
      step(1, i % 16, 1, 0);
      wraps    += int'(wrap_pulse);
      mis_seen += int'(mismatch);
      if (i == 16) check("up_wrap_at_15_to_0", int'(wrap_pulse), 1);
      check("up_locked", int'(locked), 1);
    end
    check("up_wrap_total", wraps, 1);
    check("up_mismatch_total", mis_seen, 0);
    check("up_errcnt", int'(error_count), 0);

    // Down-count 3,2,1,0,15
    do_reset();
    step(1, 3, 0, 0); step(1, 2, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check("dn_no_wrap_yet", int'(wrap_pulse), 0);
    step(1, 15, 0, 0);
    check("dn_wrap", int'(wrap_pulse), 1);
    check("dn_expected", int'(expected_out), 14);

    // Break the sequence then re-lock
    do_reset();
    for (int i = 0; i <= 5; i++) step(1, i, 1, 0);
    step(1, 9, 1, 0);
    check("brk_mismatch", int'(mismatch), 1);
    check("brk_errcnt", int'(error_count), 1);
    check("brk_locked", int'(locked), 0);
    step(1, 10, 1, 0);
    check("brk_no_second_pulse", int'(mismatch), 0);
    check("brk_still_unlocked", int'(locked), 0);
    step(1, 11, 1, 0);
    check("brk_relocked", int'(locked), 1);
    check("brk_errcnt_hold", int'(error_count), 1);

    // Clear together with a matching sample
    do_reset();
    for (int i = 0; i <= 6; i++) step(1, i, 1, 0);
    step(1, 7, 1, 1);
    check("clr_match", int'(mismatch), 0);
    check("clr_expected", int'(expected_out), 0);
    step(1, 0, 1, 0);
    check("clr_zero_ok", int'(mismatch), 0);
    check("clr_locked", int'(locked), 1);
    check("clr_no_wrap", int'(wrap_pulse), 0);

    // Sixteen mismatch/relock rounds saturate the tally
    do_reset();
    x = 0;
    step(1, x, 1, 0);
    for (int r = 0; r < 16; r++) begin
      x = (x + 5) % 16;
      step(1, x, 1, 0);
      check("sat_pulse", int'(mismatch), 1);
      x = (x + 1) % 16; step(1, x, 1, 0);
      x = (x + 1) % 16; step(1, x, 1, 0);
      check("sat_relock", int'(locked), 1);
    end
    check("sat_errcnt", int'(error_count), 15);
    step(1, (x + 8) % 16, 1, 0);
    check("sat_errcnt_stays", int'(error_count), 15);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 4; i <= 8; i++) step(1, i, 1, 0);
    #2;
    rst = 0;
    #1;
    check("arst_expected", int'(expected_out), 0);
    check("arst_locked",   int'(locked), 0);
    check("arst_errcnt",   int'(error_count), 0);
    check("arst_mismatch", int'(mismatch), 0);
    #1;
    rst = 1;
    step(1, 12, 1, 0);
    check("arst_first_no_cmp", int'(mismatch), 0);
    check("arst_first_locks", int'(locked), 1);
    step(1, 13, 1, 0);
    check("arst_second_ok", int'(mismatch), 0);

    // Randomized traffic, mostly following the predicted sequence
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) != 0) ? m_exp : int'($urandom_range(0, MODN - 1)),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 15) == 0);
      end
    end

    en = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
